// File: rtl/muldiv_wakeup_ctrl_pkg.sv
// Shared definitions for the mul/div issue port: controller state encoding and default latencies.
package muldiv_wakeup_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int CNT_W         = 6;
    localparam int DEF_MUL_LAT   = 4;
    localparam int DEF_DIV_LAT   = 32;
    localparam int DEF_WAKE_LEAD = 2;

endpackage

// File: rtl/lat_down_counter.sv
// Loadable down-counter that parks at zero; clear and reset both force it to zero.
module lat_down_counter
    import muldiv_wakeup_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (!zero) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/muldiv_wakeup_ctrl.sv
// Mul/div issue controller: tracks one in-flight op, broadcasts an early wakeup tag and a completion pulse.
module muldiv_wakeup_ctrl
    import muldiv_wakeup_ctrl_pkg::*;
#(
    parameter int PRF_WIDTH = 6,
    parameter int MUL_LAT   = DEF_MUL_LAT,
    parameter int DIV_LAT   = DEF_DIV_LAT,
    parameter int WAKE_LEAD = DEF_WAKE_LEAD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_vld,
    output logic                 issue_rdy,
    input  logic [PRF_WIDTH-1:0] issue_prd,
    input  logic                 issue_prd_v,
    input  logic                 issue_is_div,
    input  logic                 flush,
    output logic                 wk_vld,
    output logic [PRF_WIDTH-1:0] wk_tag,
    output logic                 done_vld,
    output logic [PRF_WIDTH-1:0] done_prd,
    output logic                 busy
);

    // Counter holds L-1 in the first RUN cycle, so it reads 0 exactly L cycles after accept.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] WK_CNT   = CNT_W'(WAKE_LEAD);

    state_t               state;
    logic [PRF_WIDTH-1:0] prd_q;
    logic                 prd_v_q;
    logic [CNT_W-1:0]     count;
    logic                 cnt_zero;
    logic                 complete;
    logic                 accept;

    lat_down_counter u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush),
        .load     (accept),
        .load_val (issue_is_div ? DIV_LOAD : MUL_LOAD),
        .count    (count),
        .zero     (cnt_zero)
    );

    assign complete  = (state == RUN) && cnt_zero;
    assign issue_rdy = ((state == IDLE) || complete) && !flush;
    assign accept    = issue_vld && issue_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            prd_q   <= '0;
            prd_v_q <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
        end else if (accept) begin
            state   <= RUN;
            prd_q   <= issue_prd;
            prd_v_q <= issue_prd_v;
        end else if (complete) begin
            state <= IDLE;
        end
    end

    // Flush must silence both broadcasts in the very cycle it is raised, hence the gating here.
    assign wk_vld   = (state == RUN) && prd_v_q && (count == WK_CNT) && !flush;
    assign wk_tag   = wk_vld ? prd_q : '0;
    assign done_vld = complete && !flush;
    assign done_prd = (done_vld && prd_v_q) ? prd_q : '0;
    assign busy     = (state == RUN);

endmodule

// File: tb/tb_muldiv_wakeup_ctrl.sv
// Directed scenarios plus random traffic, checked every cycle against a timestamp-based model of the controller.
module tb_muldiv_wakeup_ctrl;

    localparam int PW   = 6;
    localparam int MLAT = 4;
    localparam int DLAT = 32;
    localparam int WL   = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          issue_vld = 1'b0;
    logic          issue_rdy;
    logic [PW-1:0] issue_prd = '0;
    logic          issue_prd_v = 1'b0;
    logic          issue_is_div = 1'b0;
    logic          flush = 1'b0;
    logic          wk_vld;
    logic [PW-1:0] wk_tag;
    logic          done_vld;
    logic [PW-1:0] done_prd;
    logic          busy;

    always #5 clk = ~clk;

    muldiv_wakeup_ctrl #(
        .PRF_WIDTH (PW),
        .MUL_LAT   (MLAT),
        .DIV_LAT   (DLAT),
        .WAKE_LEAD (WL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_vld    (issue_vld),
        .issue_rdy    (issue_rdy),
        .issue_prd    (issue_prd),
        .issue_prd_v  (issue_prd_v),
        .issue_is_div (issue_is_div),
        .flush        (flush),
        .wk_vld       (wk_vld),
        .wk_tag       (wk_tag),
        .done_vld     (done_vld),
        .done_prd     (done_prd),
        .busy         (busy)
    );

    int checks = 0;
    int passes = 0;

    // Reference model: the op in flight is remembered by its accept cycle and latency.
    int          cyc = 0;
    bit          m_known = 0;
    bit          m_act = 0;
    int          m_t = 0;
    int          m_lat = 0;
    logic [PW-1:0] m_prd = '0;
    bit          m_pv = 0;
    int          wk_seen = 0;
    int          done_seen = 0;

    function automatic bit exp_rdy(input bit fl);
        return (!m_act || (cyc - m_t == m_lat)) && !fl;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    endtask

    task automatic check_outputs();
        bit e_done, e_wk;
        e_done = m_act && (cyc - m_t == m_lat) && !flush;
        e_wk   = m_act && m_pv && (cyc - m_t == m_lat - WL) && !flush;
        chk("issue_rdy", 32'(issue_rdy), 32'(exp_rdy(flush)));
        chk("busy",      32'(busy),      32'(m_act));
        chk("wk_vld",    32'(wk_vld),    32'(e_wk));
        chk("wk_tag",    32'(wk_tag),    e_wk ? 32'(m_prd) : 32'd0);
        chk("done_vld",  32'(done_vld),  32'(e_done));
        chk("done_prd",  32'(done_prd),  (e_done && m_pv) ? 32'(m_prd) : 32'd0);
    endtask

    task automatic model_update();
        if (rst) begin
            m_act   = 0;
            m_known = 1;
        end else if (m_known) begin
            if (flush) begin
                m_act = 0;
            end else if (issue_vld && exp_rdy(1'b0)) begin
                m_act = 1;
                m_t   = cyc;
                m_lat = issue_is_div ? DLAT : MLAT;
                m_prd = issue_prd;
                m_pv  = issue_prd_v;
            end else if (m_act && (cyc - m_t == m_lat)) begin
                m_act = 0;
            end
        end
        cyc++;
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance the model at the edge.
    task automatic cycle(input logic v, input logic [PW-1:0] prd, input logic pv,
                         input logic dv, input logic fl, input logic r);
        issue_vld    = v;
        issue_prd    = prd;
        issue_prd_v  = pv;
        issue_is_div = dv;
        flush        = fl;
        rst          = r;
        @(negedge clk);
        if (m_known) begin
            check_outputs();
            if (wk_vld === 1'b1) wk_seen++;
            if (done_vld === 1'b1) done_seen++;
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset and idle
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        // Single multiply, prd 0x15
        cycle(1'b1, 6'h15, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(6);
        // Divide with issue_vld held while not ready
        cycle(1'b1, 6'h2A, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 31; i++) cycle(1'b1, 6'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);
        // Back-to-back multiplies
        cycle(1'b1, 6'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
        cycle(1'b1, 6'h07, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(6);
        // Divide killed by flush at T+10
        cycle(1'b1, 6'h33, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(9);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(30);
        // Multiply without destination register
        cycle(1'b1, 6'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(6);
        // Divide aborted by reset at T+5
        cycle(1'b1, 6'h2B, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(4);
        cycle(1'b1, 6'h01, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(40);
        chk("directed_wk_count",   32'(wk_seen),   32'd4);
        chk("directed_done_count", 32'(done_seen), 32'd5);
        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(1)), 6'($urandom_range(63)), 1'($urandom_range(3) != 0),
                  1'($urandom_range(3) == 0), 1'($urandom_range(24) == 0),
                  1'($urandom_range(79) == 0));
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
